// File: rtl/i2c_scl_generator.sv
// I2C SCL timing generator: four-quarter SCL period with registered phase strobes
// and slave clock-stretch support during the high phase.

module i2c_scl_generator (
    input  logic       PCLK_i,
    input  logic       PRESET_i,
    input  logic       EN_i,
    input  logic [7:0] PRESCALER_i,
    input  logic       SCL_IN_i,
    output logic       SCL_O,
    output logic       SCL_FALL_O,
    output logic       DATA_TICK_O,
    output logic       SAMPLE_TICK_O,
    output logic       PERIOD_DONE_O,
    output logic       STRETCH_O,
    output logic       BUSY_O
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLowA  = 3'd1;
    localparam logic [2:0] StLowB  = 3'd2;
    localparam logic [2:0] StHighA = 3'd3;
    localparam logic [2:0] StHighB = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] p_lat_q, p_lat_d;
    logic       fall_q, fall_d;
    logic       data_q, data_d;
    logic       sample_q, sample_d;
    logic       done_q, done_d;
    logic       quarter_end;

    assign quarter_end = (cnt_q == p_lat_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        p_lat_d = p_lat_q;
        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (EN_i) begin
                    state_d = StLowA;
                    p_lat_d = PRESCALER_i;
                end
            end
            StLowA: begin
                if (quarter_end) begin
                    state_d = StLowB;
                    cnt_d   = 8'd0;
                end
            end
            StLowB: begin
                if (quarter_end) begin
                    state_d = StHighA;
                    cnt_d   = 8'd0;
                end
            end
            StHighA: begin
                // A slave holding SCL low freezes the quarter count.
                if (!SCL_IN_i) begin
                    cnt_d = cnt_q;
                end else if (quarter_end) begin
                    state_d = StHighB;
                    cnt_d   = 8'd0;
                end
            end
            StHighB: begin
                if (quarter_end) begin
                    cnt_d = 8'd0;
                    if (EN_i) begin
                        state_d = StLowA;
                        p_lat_d = PRESCALER_i;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Strobes are precomputed from the next state so they align with the state they mark.
    always_comb begin
        fall_d   = (state_d == StLowA) && (state_q != StLowA);
        data_d   = (state_d == StLowB) && (state_q != StLowB);
        sample_d = (state_d == StHighB) && (state_q != StHighB);
        done_d   = (state_d == StHighB) && (cnt_d == p_lat_d);
    end

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            p_lat_q  <= 8'd0;
            fall_q   <= 1'b0;
            data_q   <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_lat_q  <= p_lat_d;
            fall_q   <= fall_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign SCL_O         = !((state_q == StLowA) || (state_q == StLowB));
    assign SCL_FALL_O    = fall_q;
    assign DATA_TICK_O   = data_q;
    assign SAMPLE_TICK_O = sample_q;
    assign PERIOD_DONE_O = done_q;
    assign STRETCH_O     = (state_q == StHighA) && !SCL_IN_i;
    assign BUSY_O        = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Bench for i2c_scl_generator: cycle table for P=0 behaviour, then measured
// strobe offsets for longer prescalers, stretching, enable drop and reset.

module tb_i2c_scl_generator;

    logic       clk = 1'b0;
    logic       rst, en, hold_low;
    logic [7:0] presc;
    logic       scl_in, scl_o, scl_fall, data_tick, sample_tick, period_done, stretch, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it low.
    assign scl_in = scl_o & ~hold_low;

    i2c_scl_generator dut (
        .PCLK_i        (clk),
        .PRESET_i      (rst),
        .EN_i          (en),
        .PRESCALER_i   (presc),
        .SCL_IN_i      (scl_in),
        .SCL_O         (scl_o),
        .SCL_FALL_O    (scl_fall),
        .DATA_TICK_O   (data_tick),
        .SAMPLE_TICK_O (sample_tick),
        .PERIOD_DONE_O (period_done),
        .STRETCH_O     (stretch),
        .BUSY_O        (busy)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       hold;
        logic [6:0] exp;  // {scl, fall, data, sample, done, stretch, busy}
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {scl_o, scl_fall, data_tick, sample_tick, period_done, stretch, busy};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fall(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            #1;
            if (scl_fall) found = 1'b1;
        end
        check(name, int'(found), 1);
    endtask

    // Starts on an observed SCL_FALL cycle (offset 0); records first offsets of each event.
    task automatic run_period(input int limit, input int hold_start, input int hold_len,
                              input int chg_at, input logic [7:0] chg_val,
                              input int en_drop_at,
                              output int t_data, output int t_sample, output int t_done,
                              output int t_next, output int t_idle, output int n_stretch);
        t_data = -1; t_sample = -1; t_done = -1; t_next = -1; t_idle = -1; n_stretch = 0;
        for (int o = 1; o <= limit && t_next < 0; o++) begin
            tick();
            hold_low = (o >= hold_start) && (o < hold_start + hold_len);
            if (o == chg_at) presc = chg_val;
            if (o == en_drop_at) en = 1'b0;
            #1;
            if (data_tick && t_data < 0) t_data = o;
            if (sample_tick && t_sample < 0) t_sample = o;
            if (period_done && t_done < 0) t_done = o;
            if (!busy && t_idle < 0) t_idle = o;
            if (stretch) n_stretch++;
            if (scl_fall) t_next = o;
        end
        hold_low = 1'b0;
    endtask

    int td, ts, tdn, tn, ti, ns;

    initial begin
        rst = 1'b1; en = 1'b0; hold_low = 1'b0; presc = 8'd0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'b1000000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 7'b0100001};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 7'b0010001};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7'b1000001};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 7'b1001101};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 7'b0100001};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 7'b0010001};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 7'b1000001};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 7'b1001101};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'b0100001};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 7'b0010001};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 7'b1000011};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 7'b1000011};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7'b1001101};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 7'b1000000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7'b1000000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 7'b0100001};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 7'b1000000};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 7'b0100001};

        for (int i = 0; i < 19; i++) begin
            rst      = vecs[i].rst;
            en       = vecs[i].en;
            hold_low = vecs[i].hold;
            tick();
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got %b expected %b", i, outs(), vecs[i].exp);
            end
        end
        hold_low = 1'b0;

        // P=4: plain, stretched by 7, then plain again.
        en = 1'b0; presc = 8'd4;
        do_reset();
        en = 1'b1;
        wait_fall("p4_start");
        run_period(40, -1, 0, -1, 8'd0, -1, td, ts, tdn, tn, ti, ns);
        check("p4_data", td, 5);
        check("p4_sample", ts, 15);
        check("p4_done", tdn, 19);
        check("p4_period", tn, 20);
        run_period(60, 10, 7, -1, 8'd0, -1, td, ts, tdn, tn, ti, ns);
        check("str_count", ns, 7);
        check("str_sample", ts, 22);
        check("str_done", tdn, 26);
        check("str_period", tn, 27);
        run_period(40, -1, 0, -1, 8'd0, -1, td, ts, tdn, tn, ti, ns);
        check("post_str_period", tn, 20);

        // Prescaler 4 -> 1 in HIGH_A: takes effect only on the following period.
        run_period(40, -1, 0, 12, 8'd1, -1, td, ts, tdn, tn, ti, ns);
        check("chg_cur_sample", ts, 15);
        check("chg_cur_period", tn, 20);
        run_period(40, -1, 0, -1, 8'd0, -1, td, ts, tdn, tn, ti, ns);
        check("chg_next_data", td, 2);
        check("chg_next_sample", ts, 6);
        check("chg_next_done", tdn, 7);
        check("chg_next_period", tn, 8);

        // Enable dropped during LOW_B with P=2.
        en = 1'b0; presc = 8'd2;
        do_reset();
        en = 1'b1;
        wait_fall("p2_start");
        run_period(24, -1, 0, -1, 8'd0, 4, td, ts, tdn, tn, ti, ns);
        check("endrop_done", tdn, 11);
        check("endrop_idle", ti, 12);
        check("endrop_no_fall", tn, -1);
        check("endrop_scl", int'(scl_o), 1);
        check("endrop_busy", int'(busy), 0);

        // Reset during a stretched HIGH_A.
        presc = 8'd4;
        do_reset();
        en = 1'b1;
        wait_fall("rst_start");
        for (int o = 1; o <= 12; o++) begin
            tick();
            hold_low = (o >= 10);
            #1;
        end
        check("rst_pre_stretch", int'(stretch), 1);
        rst = 1'b1;
        tick();
        check("rst_outs", int'(outs()), int'(7'b1000000));
        rst = 1'b0;
        hold_low = 1'b0;
        tick();
        check("rst_refall", int'({scl_fall, busy, scl_o}), int'(3'b110));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_scl_generator.md
# i2c_scl_generator

Bit-level SCL timing generator for the I2C master core. Consumes the prescaler value and the enable bit of the command register from the APB register block. Produces the SCL drive level plus single-cycle phase strobes (SCL fall, data-change point, sample point, period end) that the byte shifter and the start/stop sequencer use. Supports slave clock stretching through the sensed SCL line.

## Interface
- No parameters; all widths are fixed.
- PCLK_i  in  1  system clock; all logic on its rising edge.
- PRESET_i  in  1  reset; synchronous, active-high.
- EN_i  in  1  run request (CMD enable bit); level-sensitive.
- PRESCALER_i  in  8  quarter-period length minus one (P).
- SCL_IN_i  in  1  sensed SCL line level; already synchronised to PCLK_i upstream.
- SCL_O  out  1  SCL drive: 0 = pull low, 1 = release (high).
- SCL_FALL_O  out  1  1-cycle pulse on the first cycle of SCL low.
- DATA_TICK_O  out  1  1-cycle pulse at mid-low (SDA may change).
- SAMPLE_TICK_O  out  1  1-cycle pulse at mid-high (SDA sample point).
- PERIOD_DONE_O  out  1  1-cycle pulse on the last cycle of each SCL period.
- STRETCH_O  out  1  high while a slave holds SCL low during the high phase.
- BUSY_O  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B.
- SCL_O is 0 in LOW_A and LOW_B, and 1 in IDLE, HIGH_A and HIGH_B. It is decoded from the state register only, with no extra flop.
- Quarter counter cnt (8 bit) clears to 0 on every state entry and increments each cycle.
- A state exits when cnt == p_lat, giving quarter length L = p_lat + 1 cycles (P=0 gives L=1; P=255 gives L=256). No wrap is possible.
- p_lat latches PRESCALER_i on every transition into LOW_A (from IDLE or from HIGH_B). Changes to PRESCALER_i mid-period have no effect until the next period.
- Transitions:
  - IDLE → LOW_A when EN_i = 1.
  - LOW_A → LOW_B, and LOW_B → HIGH_A, at quarter end.
  - HIGH_A → HIGH_B at quarter end.
  - HIGH_B → LOW_A at quarter end if EN_i = 1, otherwise → IDLE.
- Clock stretching: in HIGH_A, cnt advances only in cycles with SCL_IN_i = 1. STRETCH_O = (state == HIGH_A) & ~SCL_IN_i. Stretch length is unbounded (no timeout in this block).
- EN_i = 0 mid-period: the current period always completes, PERIOD_DONE_O pulses, then the FSM enters IDLE. EN_i is ignored except in IDLE and at HIGH_B quarter end.
- Strobes are registered, high for exactly one cycle:
  - SCL_FALL_O: first cycle of LOW_A.
  - DATA_TICK_O: first cycle of LOW_B.
  - SAMPLE_TICK_O: first cycle of HIGH_B.
  - PERIOD_DONE_O: last cycle of HIGH_B.
- When L = 1, SAMPLE_TICK_O and PERIOD_DONE_O are asserted in the same cycle.
- BUSY_O = (state != IDLE).

## Timing
- Reset, and reset mid-operation: at the next PCLK_i edge with PRESET_i = 1, the FSM goes to IDLE and cnt and p_lat clear to 0.
- Reset values: SCL_O = 1; SCL_FALL_O, DATA_TICK_O, SAMPLE_TICK_O, PERIOD_DONE_O, STRETCH_O and BUSY_O all 0.
- Reset has priority over EN_i.
- Start latency: EN_i = 1 sampled at edge k. From edge k the state is LOW_A, SCL_O = 0, SCL_FALL_O = 1 and BUSY_O = 1 for the cycle following edge k.
- Unstretched period = 4L cycles. Stretched period = 4L + number of HIGH_A cycles with SCL_IN_i = 0.
- Strobe offsets relative to SCL_FALL_O: DATA_TICK_O at +L, SCL_O rises at +2L, SAMPLE_TICK_O at +3L (+stretch), PERIOD_DONE_O at +4L−1 (+stretch).
- Back-to-back periods: SCL_FALL_O of the next period follows PERIOD_DONE_O on the very next cycle, with no gap.

## Test plan
- P = 0, EN_i held high, SCL_IN_i = SCL_O → SCL_O repeats 0,0,1,1 with period 4. All four strobes fire each period. BUSY_O = 1.
- P = 4, EN_i high → SCL low 10 / high 10 cycles. Offsets from SCL_FALL_O: DATA_TICK_O +5, SAMPLE_TICK_O +15, PERIOD_DONE_O +19.
- P = 4, SCL_IN_i forced low for 7 cycles starting at HIGH_A entry → STRETCH_O high for exactly 7 cycles. SAMPLE_TICK_O at +22, period 27 cycles. Next period returns to 20.
- EN_i dropped during LOW_B (P = 2) → period completes (12 cycles), PERIOD_DONE_O pulses. Next cycle: IDLE, SCL_O = 1, BUSY_O = 0, no further SCL_FALL_O.
- PRESCALER_i changed 4 → 1 in the middle of HIGH_A → current period 20 cycles, following period 8 cycles.
- PRESET_i asserted for 1 cycle during HIGH_A of a stretched period → next cycle IDLE, all outputs at reset values. With EN_i still high, SCL_FALL_O fires on the cycle after PRESET_i is released.
